jbi_min_rqn: RTL

Parametrised multi-channel request queue for the JBI min path: NCH independent header/data FIFO pairs feeding one round-robin issue engine toward the L2 sctag request port. It generalises the single header/data queue pair with configurable channel count, depth and width, and adds credit-based IQ flow control, a programmable write-invalidate outstanding limit and per-channel full flags. It sits between the write-decode (wdq) stage and the sctag interface, entirely in the `clk` domain.

---
 rtl/jbi_min_rqn.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jbi_min_rqn.sv
// jbi_min_rqn: NCH header/data FIFO pairs feeding a round-robin issue engine toward the L2 sctag.
// Defining JBI_RQ_L2_TIMEOUT_EN adds the stall timeout counter driving min_csr_err_l2_to.
module jbi_min_rqn #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned W          = 64,
  parameter int unsigned HDEPTH     = 16,
  parameter int unsigned DDEPTH     = 32,
  parameter int unsigned DATA_BEATS = 2,
  parameter int unsigned IQ_CREDITS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_l,
  input  logic [NCH-1:0]                          wdq_hdr_push,
  input  logic [NCH-1:0]                          wdq_hdr_rw,
  input  logic [NCH*W-1:0]                        wdq_hdr_wdata,
  input  logic [NCH-1:0]                          wdq_dat_push,
  input  logic [NCH*W-1:0]                        wdq_dat_wdata,
  input  logic                                    sctag_jbi_iq_dequeue,
  input  logic                                    sctag_jbi_wib_dequeue,
  input  logic [1:0]                              csr_jbi_config2_max_wris,
  input  logic [31:0]                             csr_jbi_l2_timeout_timeval,
  output logic [NCH-1:0]                          rhq_full,
  output logic [NCH-1:0]                          rdq_full,
  output logic                                    jbi_sctag_req_vld,
  output logic                                    jbi_sctag_req_hdr,
  output logic [W-1:0]                            jbi_sctag_req,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] issue_ch,
  output logic                                    min_csr_err_l2_to
);
  localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned HAw = $clog2(HDEPTH);
  localparam int unsigned DAw = $clog2(DDEPTH);
  localparam int unsigned CrW = $clog2(IQ_CREDITS + 1);
  localparam int unsigned BtW = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic [HAw:0] HFull  = (HAw + 1)'(HDEPTH);
  localparam logic [DAw:0] DFull  = (DAw + 1)'(DDEPTH);
  localparam logic [DAw:0] DBeats = (DAw + 1)'(DATA_BEATS);
  localparam logic [CrW-1:0] CrMax = CrW'(IQ_CREDITS);
  localparam logic [BtW-1:0] LastBeat = BtW'(DATA_BEATS - 1);

  typedef enum logic [0:0] {StIdle, StData} state_e;

  logic [W:0]     hmem_q [NCH][HDEPTH];
  logic [W-1:0]   dmem_q [NCH][DDEPTH];
  logic [HAw-1:0] hwp_q [NCH];
  logic [HAw-1:0] hrp_q [NCH];
  logic [HAw:0]   hcnt_q [NCH];
  logic [HAw:0]   hcnt_d [NCH];
  logic [DAw-1:0] dwp_q [NCH];
  logic [DAw-1:0] drp_q [NCH];
  logic [DAw:0]   dcnt_q [NCH];
  logic [DAw:0]   dcnt_d [NCH];
  logic [W:0]     hhead [NCH];
  logic [W-1:0]   dhead [NCH];

  logic [NCH-1:0] hpush_ok, dpush_ok, hpop, dpop, elig, hnempty;
  logic [NCH-1:0] rhq_full_d, rdq_full_d, rhq_full_q, rdq_full_q;

  state_e         state_q, state_d;
  logic [BtW-1:0] beat_q, beat_d;
  logic [ChW-1:0] cur_q, cur_d, last_q, last_d, grant, issue_q, issue_d;
  logic [CrW-1:0] credit_q, credit_d;
  logic [2:0]     wri_q, wri_d;
  logic [3:0]     wri_lim;
  logic           wri_ok, grant_vld, hdr_issue, wr_issue;
  logic           vld_q, vld_d, hdr_q, hdr_d;
  logic [W-1:0]   req_q, req_d;
  int unsigned    idx;

  assign wri_lim = {2'b00, csr_jbi_config2_max_wris} + 4'd1;
  assign wri_ok  = ({1'b0, wri_q} < wri_lim);

  // Eligibility only looks at registered state, so it never depends on this cycle's pops.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      hhead[c]   = hmem_q[c][hrp_q[c]];
      dhead[c]   = dmem_q[c][drp_q[c]];
      hnempty[c] = (hcnt_q[c] != '0);
      elig[c]    = hnempty[c] && (credit_q != '0) &&
                   (!hhead[c][W] || ((dcnt_q[c] >= DBeats) && wri_ok));
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      hpush_ok[c]   = wdq_hdr_push[c] && ((hcnt_q[c] != HFull) || hpop[c]);
      dpush_ok[c]   = wdq_dat_push[c] && ((dcnt_q[c] != DFull) || dpop[c]);
      hcnt_d[c]     = hcnt_q[c] + (HAw + 1)'(hpush_ok[c]) - (HAw + 1)'(hpop[c]);
      dcnt_d[c]     = dcnt_q[c] + (DAw + 1)'(dpush_ok[c]) - (DAw + 1)'(dpop[c]);
      rhq_full_d[c] = (hcnt_d[c] == HFull);
      rdq_full_d[c] = (dcnt_d[c] == DFull);
    end
  end

  always_comb begin
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (32'(last_q) + 32'(i)) % NCH;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = ChW'(idx);
      end
    end

    state_d   = state_q;
    beat_d    = beat_q;
    cur_d     = cur_q;
    last_d    = last_q;
    issue_d   = issue_q;
    vld_d     = 1'b0;
    hdr_d     = 1'b0;
    req_d     = '0;
    hpop      = '0;
    dpop      = '0;
    hdr_issue = 1'b0;
    wr_issue  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          hpop[grant] = 1'b1;
          hdr_issue   = 1'b1;
          vld_d       = 1'b1;
          hdr_d       = 1'b1;
          req_d       = hhead[grant][W-1:0];
          issue_d     = grant;
          last_d      = grant;
          if (hhead[grant][W]) begin
            wr_issue = 1'b1;
            state_d  = StData;
            cur_d    = grant;
            beat_d   = '0;
          end
        end
      end
      StData: begin
        dpop[cur_q] = 1'b1;
        vld_d       = 1'b1;
        req_d       = dhead[cur_q];
        issue_d     = cur_q;
        beat_d      = beat_q + BtW'(1);
        if (beat_q == LastBeat) state_d = StIdle;
      end
    endcase

    credit_d = credit_q;
    if (hdr_issue && !sctag_jbi_iq_dequeue) begin
      credit_d = credit_q - CrW'(1);
    end else if (!hdr_issue && sctag_jbi_iq_dequeue && (credit_q != CrMax)) begin
      credit_d = credit_q + CrW'(1);
    end

    wri_d = wri_q;
    if (wr_issue && !sctag_jbi_wib_dequeue && (wri_q != 3'd7)) begin
      wri_d = wri_q + 3'd1;
    end else if (!wr_issue && sctag_jbi_wib_dequeue && (wri_q != 3'd0)) begin
      wri_d = wri_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      cur_q      <= '0;
      last_q     <= ChW'(NCH - 1);
      issue_q    <= '0;
      vld_q      <= 1'b0;
      hdr_q      <= 1'b0;
      req_q      <= '0;
      credit_q   <= CrMax;
      wri_q      <= '0;
      rhq_full_q <= '0;
      rdq_full_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        hwp_q[c]  <= '0;
        hrp_q[c]  <= '0;
        hcnt_q[c] <= '0;
        dwp_q[c]  <= '0;
        drp_q[c]  <= '0;
        dcnt_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      issue_q    <= issue_d;
      vld_q      <= vld_d;
      hdr_q      <= hdr_d;
      req_q      <= req_d;
      credit_q   <= credit_d;
      wri_q      <= wri_d;
      rhq_full_q <= rhq_full_d;
      rdq_full_q <= rdq_full_d;
      for (int c = 0; c < NCH; c++) begin
        if (hpush_ok[c]) hwp_q[c] <= hwp_q[c] + HAw'(1);
        if (hpop[c])     hrp_q[c] <= hrp_q[c] + HAw'(1);
        if (dpush_ok[c]) dwp_q[c] <= dwp_q[c] + DAw'(1);
        if (dpop[c])     drp_q[c] <= drp_q[c] + DAw'(1);
        hcnt_q[c] <= hcnt_d[c];
        dcnt_q[c] <= dcnt_d[c];
      end
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (hpush_ok[c]) hmem_q[c][hwp_q[c]] <= {wdq_hdr_rw[c], wdq_hdr_wdata[c*W +: W]};
      if (dpush_ok[c]) dmem_q[c][dwp_q[c]] <= wdq_dat_wdata[c*W +: W];
    end
  end

`ifdef JBI_RQ_L2_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        err_q, err_d;

  always_comb begin
    err_d    = 1'b0;
    to_cnt_d = to_cnt_q + 32'd1;
    if (hdr_issue || (hnempty == '0)) begin
      to_cnt_d = '0;
    end else if ((csr_jbi_l2_timeout_timeval != '0) &&
                 (to_cnt_q + 32'd1 == csr_jbi_l2_timeout_timeval)) begin
      err_d    = 1'b1;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign min_csr_err_l2_to = err_q;
`else
  logic unused_timeval;
  assign unused_timeval    = ^csr_jbi_l2_timeout_timeval;
  assign min_csr_err_l2_to = 1'b0;
`endif

  assign rhq_full          = rhq_full_q;
  assign rdq_full          = rdq_full_q;
  assign jbi_sctag_req_vld = vld_q;
  assign jbi_sctag_req_hdr = hdr_q;
  assign jbi_sctag_req     = req_q;
  assign issue_ch          = issue_q;
endmodule
